// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle of the PS/2 host transmitter.
// The master issues bytes and watches status; the slave is the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_active;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_active, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_active, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts start/data/parity/stop out on device clock falls and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int DEB_LEN        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_host_tx_if.slave   bus,
    input  logic           ps_clk_in,
    input  logic           ps_data_in,
    output logic           ps_clk_oe,
    output logic           ps_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEB_W = $clog2(DEB_LEN + 1);
    localparam int CLK_I = 0;
    localparam int DAT_I = 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    // Pad conditioning: bit CLK_I is ps_clk, bit DAT_I is ps_data.
    logic [1:0]       sync_q1, sync_q2, filt;
    logic [DEB_W-1:0] deb_cnt [2];
    logic             fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
            filt    <= '1;
            // NOTE: a two-entry counter array is plain flops, so it is reset like any register.
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
            fall    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync_q1 <= {ps_data_in, ps_clk_in};
            sync_q2 <= sync_q1;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_LEN - 1)) begin
                    filt[i]    <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            fall <= filt[CLK_I] & ~sync_q2[CLK_I] & (deb_cnt[CLK_I] == DEB_W'(DEB_LEN - 1));
        end
    end

    state_t           state, state_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [8:0]       shreg, shreg_n;
    logic             ack_flag, ack_flag_n;
    logic             clk_oe_q, clk_oe_n;
    logic             data_oe_q, data_oe_n;
    logic             done_q, done_n;
    logic             ack_err_q, ack_err_n;
    logic             to_err_q, to_err_n;
    logic             in_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ack_flag  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state     <= state_n;
            inh_cnt   <= inh_cnt_n;
            to_cnt    <= to_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ack_flag  <= ack_flag_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            ack_err_q <= ack_err_n;
            to_err_q  <= to_err_n;
        end
    end

    assign in_xfer = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n    = state;
        inh_cnt_n  = inh_cnt;
        to_cnt_n   = to_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ack_flag_n = ack_flag;
        clk_oe_n   = 1'b0;
        data_oe_n  = data_oe_q;
        done_n     = 1'b0;
        ack_err_n  = 1'b0;
        to_err_n   = 1'b0;

        unique case (state)
            IDLE: begin
                data_oe_n = 1'b0;
                if (bus.tx_valid) begin
                    state_n    = INHIBIT;
                    shreg_n    = {~^bus.tx_data, bus.tx_data};
                    inh_cnt_n  = '0;
                    ack_flag_n = 1'b0;
                    clk_oe_n   = 1'b1;
                    data_oe_n  = (INHIBIT_CYCLES == 1);
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_n   = REQ;
                    to_cnt_n  = '0;
                    bit_cnt_n = '0;
                end else begin
                    // Start bit goes low together with the final inhibit cycle.
                    inh_cnt_n = inh_cnt + 1'b1;
                    clk_oe_n  = 1'b1;
                    data_oe_n = (inh_cnt == INH_W'(INHIBIT_CYCLES - 2));
                end
            end
            REQ, SEND: begin
                if (fall) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9) begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b0, shreg[8:1]};
                        state_n   = SEND;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ack_flag_n = filt[DAT_I];
                    state_n    = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (filt[CLK_I] && filt[DAT_I]) begin
                    done_n    = 1'b1;
                    ack_err_n = ack_flag;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // The timeout overrides whatever the per-state logic decided this cycle.
        if (in_xfer) begin
            to_cnt_n = to_cnt + 1'b1;
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_n   = IDLE;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                done_n    = 1'b0;
                ack_err_n = 1'b0;
                to_err_n  = 1'b1;
            end
        end
    end

    assign ps_clk_oe       = clk_oe_q;
    assign ps_data_oe      = data_oe_q;
    assign bus.tx_ready    = (state == IDLE);
    assign bus.tx_active   = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a keyboard model clocks frames back
// and the sampled bits are compared with frames built from the byte rules.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TOUT = 2000;
    localparam int DEB  = 4;
    localparam int H    = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic ps_clk_in, ps_data_in, ps_clk_oe, ps_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_accept = 0, n_done = 0, n_tout = 0, n_rdy_viol = 0, n_both = 0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .DEB_LEN(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ps_clk_in(ps_clk_in),
        .ps_data_in(ps_data_in),
        .ps_clk_oe(ps_clk_oe),
        .ps_data_oe(ps_data_oe)
    );

    // Open-drain pads with pull-ups: low when either side pulls.
    assign ps_clk_in  = ~(ps_clk_oe | dev_clk_low);
    assign ps_data_in = ~(ps_data_oe | dev_data_low);

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.tx_valid && bus.tx_ready) n_accept++;
            if (bus.done === 1'b1) n_done++;
            if (bus.timeout_err === 1'b1) n_tout++;
            if (bus.tx_active && bus.tx_ready) n_rdy_viol++;
            if (bus.done && bus.timeout_err) n_both++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected line values seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_request(output int waited, output int hi, output int data_first, output bit ok);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ps_clk_oe !== 1'b1 && waited < 1000);
        hi = 0;
        data_first = -1;
        ok = (ps_clk_oe === 1'b1);
        while (ps_clk_oe === 1'b1 && hi < INH + 50) begin
            if (ps_data_oe === 1'b1 && data_first < 0) data_first = hi;
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic dev_clock(input bit give_ack, input int glitch_bit, output logic [10:0] bits);
        bits = '0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bits[i] = ps_data_in;
            if (i == 10 && give_ack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i == 10) begin
                repeat (2) @(negedge clk);
                dev_data_low = 1'b0;
            end else if (i == glitch_bit) begin
                repeat (8) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H - 10) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(output bit seen, output logic ae, output logic dn_next);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && bus.timeout_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        seen = (bus.done === 1'b1);
        ae = bus.ack_err;
        @(negedge clk);
        dn_next = bus.done;
    endtask

    task automatic test_frame(input logic [7:0] d, input bit give_ack, input int glitch_bit);
        int w, hi, df;
        bit ok, seen;
        logic [10:0] bits;
        logic ae, dn2;
        send(d);
        wait_request(w, hi, df, ok);
        checks++;
        if (!ok || hi !== INH) begin
            failures++;
            $display("FAIL inhibit_len d=%02h: got %0d cycles, expected %0d", d, hi, INH);
        end
        checks++;
        if (df !== INH - 1) begin
            failures++;
            $display("FAIL start_bit_cycle d=%02h: got %0d, expected %0d", d, df, INH - 1);
        end
        dev_clock(give_ack, glitch_bit, bits);
        checks++;
        if (bits !== frame_of(d)) begin
            failures++;
            $display("FAIL frame_bits d=%02h: got %b, expected %b", d, bits, frame_of(d));
        end
        wait_done(seen, ae, dn2);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_seen d=%02h: got 0, expected 1", d);
        end
        checks++;
        if (ae !== ~give_ack) begin
            failures++;
            $display("FAIL ack_err d=%02h: got %b, expected %b", d, ae, ~give_ack);
        end
        checks++;
        if (dn2 !== 1'b0) begin
            failures++;
            $display("FAIL done_width d=%02h: got %b, expected 0", d, dn2);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ps_clk_oe, ps_data_oe, bus.done, bus.ack_err, bus.timeout_err, bus.tx_active, bus.tx_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_outputs: got %b, expected 0000001",
                     {ps_clk_oe, ps_data_oe, bus.done, bus.ack_err, bus.timeout_err, bus.tx_active, bus.tx_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1 || ps_clk_oe !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got ready=%b clk_oe=%b, expected 1 0", bus.tx_ready, ps_clk_oe);
        end
    endtask

    task automatic test_timeout();
        int w, hi, df, n, done_before;
        bit ok;
        send(8'($urandom));
        wait_request(w, hi, df, ok);
        done_before = n_done;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < TOUT + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TOUT) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", n, TOUT);
        end
        checks++;
        if ({ps_clk_oe, ps_data_oe, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_release: got clk_oe,data_oe,done=%b, expected 000", {ps_clk_oe, ps_data_oe, bus.done});
        end
        @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after: got ready=%b timeout_err=%b, expected 1 0", bus.tx_ready, bus.timeout_err);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_done !== done_before) begin
            failures++;
            $display("FAIL timeout_no_done: got %0d done pulses, expected 0", n_done - done_before);
        end
    endtask

    task automatic test_reset_mid();
        int w, hi, df;
        bit ok;
        logic [7:0] d;
        d = 8'($urandom) & 8'hEF;
        send(d);
        wait_request(w, hi, df, ok);
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                repeat (H) @(negedge clk);
            end
        end
        checks++;
        if (ps_data_oe !== 1'b1) begin
            failures++;
            $display("FAIL bit4_driven d=%02h: got data_oe=%b, expected 1", d, ps_data_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ps_clk_oe, ps_data_oe, bus.tx_active} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_release: got clk_oe,data_oe,active=%b, expected 000", {ps_clk_oe, ps_data_oe, bus.tx_active});
        end
        dev_clk_low = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b, expected 1", bus.tx_ready);
        end
        test_frame(8'hFF, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        int w, hi, df, n, acc0;
        bit ok, seen;
        logic [10:0] bits;
        logic ae, dn2;
        logic [7:0] first;
        first = 8'($urandom);
        @(posedge clk); #1;
        acc0 = n_accept;
        bus.tx_data  = first;
        bus.tx_valid = 1'b1;
        wait_request(w, hi, df, ok);
        @(posedge clk); #1;
        bus.tx_data = 8'hF4;
        dev_clock(1'b1, -1, bits);
        checks++;
        if (bits !== frame_of(first)) begin
            failures++;
            $display("FAIL b2b_first_bits d=%02h: got %b, expected %b", first, bits, frame_of(first));
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got done=%b ready=%b, expected 1 1", bus.done, bus.tx_ready);
        end
        wait_request(w, hi, df, ok);
        checks++;
        if (w !== 1 || hi !== INH) begin
            failures++;
            $display("FAIL b2b_second_start: got wait=%0d inhibit=%0d, expected 1 %0d", w, hi, INH);
        end
        bus.tx_valid = 1'b0;
        dev_clock(1'b1, -1, bits);
        checks++;
        if (bits !== frame_of(8'hF4)) begin
            failures++;
            $display("FAIL b2b_second_bits: got %b, expected %b", bits, frame_of(8'hF4));
        end
        wait_done(seen, ae, dn2);
        checks++;
        if (!seen || ae !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_done: got seen=%b ack_err=%b, expected 1 0", seen, ae);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_accept - acc0 !== 2) begin
            failures++;
            $display("FAIL b2b_accepts: got %0d, expected 2", n_accept - acc0);
        end
        checks++;
        if (n_rdy_viol !== 0) begin
            failures++;
            $display("FAIL ready_while_active: got %0d cycles, expected 0", n_rdy_viol);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_frame(8'hED, 1'b1, -1);
        test_frame(8'h07, 1'b0, -1);
        for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'($urandom), -1);
        test_timeout();
        test_frame(8'($urandom), 1'b1, 4);
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL done_and_timeout: got %0d overlapping pulses, expected 0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
